// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port external memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS,
    ARB_ACK
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_bus_req_t;

  // Winner among the pending requests when no lock applies: on a tie, the port that did not go last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side bundle: per-port request/handshake signals and shared read data.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic [1:0]             req_i;
  logic [1:0]             lock_i;
  logic [1:0]             we_i;
  logic [1:0][ADDR_W-1:0] addr_i;
  logic [1:0][DATA_W-1:0] wdata_i;
  logic [1:0]             gnt_o;
  logic [1:0]             ack_o;
  logic [1:0]             err_o;
  logic [DATA_W-1:0]      rdata_o;

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i,
    output gnt_o, ack_o, err_o, rdata_o
  );

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i,
    input  gnt_o, ack_o, err_o, rdata_o
  );

endinterface

// File: rtl/arb_wait_timer.sv
// Counts needWait stall cycles of one bus access and flags the stall that hits the timeout.
module arb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LIMIT   = (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] CNT_MAX = '1;

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare is against the count before this stall is added, so the Nth stall expires.
  assign expired_o = (TIMEOUT_CYCLES != 0) && inc_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the external 24-bit memory bus between the CPU (port 0)
// and a DMA/debug master (port 1), with locked bursts and a stuck-bus timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] addr_o,
  output logic              re_o,
  output logic              we_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              needWait_i
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              lock_vld_q, lock_vld_d;
  logic              lock_own_q, lock_own_d;
  mem_bus_req_t      req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              tmr_clr, tmr_inc, tmr_expired;
  logic              lock_hold, have_win, win;
  logic              in_bus, in_ack;
  logic [1:0]        owner_oh;

  assign tmr_clr = (state_q == ARB_IDLE);
  assign tmr_inc = (state_q == ARB_BUS) && needWait_i;

  arb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    lock_hold  = 1'b0;
    have_win   = 1'b0;
    win        = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        lock_hold = lock_vld_q && bus.req_i[lock_own_q];
        if (lock_vld_q && !bus.req_i[lock_own_q]) begin
          lock_vld_d = 1'b0;
        end
        if (lock_hold) begin
          have_win = 1'b1;
          win      = lock_own_q;
        end else if (|bus.req_i) begin
          have_win = 1'b1;
          win      = rr_pick(bus.req_i, last_q);
        end
        if (have_win) begin
          owner_d = win;
          req_d   = '{we: bus.we_i[win], addr: bus.addr_i[win], wdata: bus.wdata_i[win]};
          state_d = ARB_BUS;
        end
      end
      ARB_BUS: begin
        if (needWait_i) begin
          if (tmr_expired) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ARB_ACK;
          end
        end else begin
          err_d   = 1'b0;
          rdata_d = req_q.we ? '0 : data_i;
          state_d = ARB_ACK;
        end
      end
      ARB_ACK: begin
        last_d     = owner_q;
        lock_vld_d = !err_q && bus.lock_i[owner_q];
        lock_own_d = owner_q;
        state_d    = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      req_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // All outputs decode from registered state only, so they are glitch-free and zero outside BUS/ACK.
  always_comb begin
    in_bus      = (state_q == ARB_BUS);
    in_ack      = (state_q == ARB_ACK);
    owner_oh    = 2'b01 << owner_q;
    bus.gnt_o   = (in_bus || in_ack) ? owner_oh : '0;
    bus.ack_o   = in_ack ? owner_oh : '0;
    bus.err_o   = (in_ack && err_q) ? owner_oh : '0;
    bus.rdata_o = in_ack ? rdata_q : '0;
    addr_o      = in_bus ? req_q.addr : '0;
    data_o      = in_bus ? req_q.wdata : '0;
    re_o        = in_bus && !req_q.we;
    we_o        = in_bus && req_q.we;
    data_oe_o   = in_bus && req_q.we;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] addr_o;
  logic        re_o, we_o, data_oe_o;
  logic [15:0] data_o, data_i;
  logic        needWait_i;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .TMR_W          (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .addr_o     (addr_o),
    .re_o       (re_o),
    .we_o       (we_o),
    .data_o     (data_o),
    .data_oe_o  (data_oe_o),
    .data_i     (data_i),
    .needWait_i (needWait_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 driving the bus, 2 acknowledging.
  bit          m_valid = 1'b0;
  int          m_phase, m_own, m_last, m_lock, m_waits, m_w;
  bit          m_we, m_err;
  logic [23:0] m_addr;
  logic [15:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_own   = 0;
      m_last  = 1;
      m_lock  = -1;
      m_waits = 0;
      m_err   = 1'b0;
      m_rdata = '0;
    end else if (m_valid) begin
      case (m_phase)
        0: begin
          m_w = -1;
          if (m_lock >= 0 && !bus.req_i[m_lock]) m_lock = -1;
          if (m_lock >= 0) m_w = m_lock;
          else if (bus.req_i == 2'b11) m_w = 1 - m_last;
          else if (bus.req_i[0]) m_w = 0;
          else if (bus.req_i[1]) m_w = 1;
          if (m_w >= 0) begin
            m_own   = m_w;
            m_we    = bus.we_i[m_w];
            m_addr  = bus.addr_i[m_w];
            m_wdata = bus.wdata_i[m_w];
            m_waits = 0;
            m_phase = 1;
          end
        end
        1: begin
          if (needWait_i) begin
            m_waits++;
            if (TO != 0 && m_waits >= TO) begin
              m_err   = 1'b1;
              m_rdata = '0;
              m_phase = 2;
            end
          end else begin
            m_err   = 1'b0;
            m_rdata = m_we ? 16'h0 : data_i;
            m_phase = 2;
          end
        end
        default: begin
          m_last  = m_own;
          m_lock  = (!m_err && bus.lock_i[m_own]) ? m_own : -1;
          m_phase = 0;
        end
      endcase
    end
  end

  logic [1:0]  e_oh;
  logic [79:0] e_vec, a_vec;

  always @(negedge clk) begin
    if (m_valid) begin
      e_oh  = 2'b01 << m_own;
      e_vec = {(m_phase != 0) ? e_oh : 2'b00,
               (m_phase == 2) ? e_oh : 2'b00,
               (m_phase == 2 && m_err) ? e_oh : 2'b00,
               (m_phase == 2) ? m_rdata : 16'h0,
               (m_phase == 1) ? m_addr : 24'h0,
               (m_phase == 1 && !m_we),
               (m_phase == 1 && m_we),
               (m_phase == 1) ? m_wdata : 16'h0,
               (m_phase == 1 && m_we)};
      a_vec = {bus.gnt_o, bus.ack_o, bus.err_o, bus.rdata_o, addr_o, re_o, we_o, data_o, data_oe_o};
      check("cycle_outputs", a_vec, e_vec);
    end
  end

  task automatic set_req(input int p, input bit r, input bit lk, input bit wr,
                         input logic [23:0] a, input logic [15:0] wd);
    bus.req_i[p]   = r;
    bus.lock_i[p]  = lk;
    bus.we_i[p]    = wr;
    bus.addr_i[p]  = a;
    bus.wdata_i[p] = wd;
  endtask

  task automatic wait_ack(output int port, output int lat, output logic [15:0] rd, output logic er);
    port = -1;
    lat  = 0;
    rd   = '0;
    er   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.ack_o != 2'b00) begin
        port = bus.ack_o[1] ? 1 : 0;
        rd   = bus.rdata_o;
        er   = |bus.err_o;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: no ack within 40 cycles, required one");
  endtask

  int          p, lat, nb;
  logic [15:0] rd;
  logic        er;
  int          exp2[4] = '{0, 1, 0, 1};
  int          exp5[4] = '{1, 1, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_i   = '0;
    bus.lock_i  = '0;
    bus.we_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    data_i      = '0;
    needWait_i  = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_gnt", bus.gnt_o, 2'b00);
    check("reset_strobes", {re_o, we_o, data_oe_o}, 3'b000);
    rst = 1'b0;

    // Single read, no wait states
    set_req(0, 1, 0, 0, 24'h000100, 16'h0);
    data_i = 16'hBEEF;
    @(negedge clk);
    check("t1_re", re_o, 1'b1);
    check("t1_addr", addr_o, 24'h000100);
    wait_ack(p, lat, rd, er);
    check("t1_port", p, 0);
    check("t1_latency", lat, 1);
    check("t1_rdata", rd, 16'hBEEF);
    check("t1_err", er, 1'b0);
    bus.req_i[0] = 1'b0;
    @(negedge clk);

    // Simultaneous requests after reset alternate 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_i = 16'h1111;
    set_req(0, 1, 0, 0, 24'h000010, 16'h0);
    set_req(1, 1, 0, 0, 24'h000020, 16'h0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(p, lat, rd, er);
      check("t2_order", p, exp2[i]);
    end
    bus.req_i = 2'b00;
    @(negedge clk);

    // Port 1 write stalled three cycles
    needWait_i = 1'b1;
    set_req(1, 1, 0, 1, 24'h123456, 16'hA5A5);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ack_o != 2'b00) break;
      if (we_o) begin
        nb++;
        check("t3_data", {data_oe_o, addr_o, data_o}, {1'b1, 24'h123456, 16'hA5A5});
        if (nb == 4) needWait_i = 1'b0;
      end
    end
    check("t3_bus_cycles", nb, 4);
    check("t3_ack", bus.ack_o, 2'b10);
    bus.req_i[1] = 1'b0;
    @(negedge clk);

    // Stuck bus aborts after TO stall cycles
    needWait_i = 1'b1;
    data_i = 16'h7777;
    set_req(0, 1, 0, 0, 24'h000200, 16'h0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ack_o != 2'b00) break;
      if (re_o) nb++;
    end
    check("t4_bus_cycles", nb, TO);
    check("t4_ack_err", {bus.ack_o, bus.err_o}, 4'b0101);
    check("t4_rdata", bus.rdata_o, 16'h0);
    check("t4_re_low", re_o, 1'b0);
    needWait_i = 1'b0;
    bus.req_i[0] = 1'b0;
    @(negedge clk);

    // Locked burst on port 1 holds off port 0
    data_i = 16'h5555;
    set_req(1, 1, 1, 0, 24'h000030, 16'h0);
    @(negedge clk);
    check("t5_gnt1", bus.gnt_o, 2'b10);
    set_req(0, 1, 0, 0, 24'h000040, 16'h0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(p, lat, rd, er);
      check("t5_order", p, exp5[i]);
      if (i == 2) begin
        bus.req_i[1]  = 1'b0;
        bus.lock_i[1] = 1'b0;
      end
      if (i == 3) bus.req_i[0] = 1'b0;
    end
    @(negedge clk);

    // Reset mid-stall abandons the access
    needWait_i = 1'b1;
    set_req(0, 1, 0, 0, 24'h000050, 16'h0);
    repeat (2) @(negedge clk);
    check("t6_in_bus", re_o, 1'b1);
    rst = 1'b1;
    set_req(1, 1, 0, 0, 24'h000060, 16'h0);
    @(negedge clk);
    check("t6_strobes_low", {re_o, we_o, bus.gnt_o, bus.ack_o}, 6'b0);
    rst = 1'b0;
    needWait_i = 1'b0;
    data_i = 16'h0ACE;
    wait_ack(p, lat, rd, er);
    check("t6_first_port", p, 0);
    check("t6_rdata", rd, 16'h0ACE);
    bus.req_i = 2'b00;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
